// File: rtl/delta_spike_decoder_pkg.sv
// Shared definitions for the delta spike decoder and its matching encoder:
// FSM states, event-kind encoding, default limits and the delta magnitude helper.
package delta_spike_decoder_pkg;

  localparam logic [7:0] DEFAULT_DELTA_THRESHOLD = 8'd10;
  localparam int         DEFAULT_STALE_LIMIT     = 255;

  typedef enum logic [1:0] {
    ST_UNSYNC = 2'd0,
    ST_SYNCED = 2'd1,
    ST_STALE  = 2'd2
  } state_t;

  typedef enum logic {
    KIND_DELTA = 1'b0,
    KIND_KEY   = 1'b1
  } kind_t;

  typedef struct packed {
    kind_t      kind;
    logic [7:0] data;
  } event_t;

  // Magnitude of a signed 8-bit delta as unsigned; -128 maps to 128.
  function automatic logic [7:0] delta_mag(input logic [7:0] d);
    return d[7] ? (~d + 8'd1) : d;
  endfunction

endpackage

// File: rtl/delta_spike_decoder_if.sv
// Event input stream and reconstructed-state output stream of the decoder.
interface delta_spike_decoder_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_kind;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_state;

  modport master (
    output in_valid, in_kind, in_data, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_kind, in_data, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/delta_event_fifo.sv
// Small power-of-two event buffer; full/empty derive from the occupancy count only.
module delta_event_fifo
  import delta_spike_decoder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  event_t push_evt,
  input  logic   pop,
  output event_t pop_evt,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  event_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_evt = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_evt;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/delta_spike_decoder.sv
// Rebuilds an 8-bit neuron state from keyframe/delta events, tracking sync,
// staleness and sticky threshold/saturation errors.
module delta_spike_decoder
  import delta_spike_decoder_pkg::*;
#(
  parameter logic [7:0] DELTA_THRESHOLD = DEFAULT_DELTA_THRESHOLD,
  parameter int         FIFO_DEPTH      = 4,
  parameter int         STALE_LIMIT     = DEFAULT_STALE_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst,
  delta_spike_decoder_if.slave  bus,
  output logic                  synced,
  output logic                  stale,
  output logic                  err_thresh,
  output logic                  err_sat
);

  localparam int IDLE_W = $clog2(STALE_LIMIT + 1);

  state_t            state_q, state_d;
  logic [7:0]        value_q, value_d;
  logic              out_valid_q, out_valid_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              err_thresh_d, err_sat_d;
  logic              fifo_full, fifo_empty, pop;
  event_t            push_evt, pop_evt;
  logic [8:0]        sum;
  logic [7:0]        mag;

  assign push_evt.kind = kind_t'(bus.in_kind);
  assign push_evt.data = bus.in_data;
  assign pop           = !fifo_empty && (!out_valid_q || bus.out_ready);

  delta_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (bus.in_valid),
    .push_evt (push_evt),
    .pop      (pop),
    .pop_evt  (pop_evt),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign bus.in_ready  = !fifo_full;
  assign bus.out_valid = out_valid_q;
  assign bus.out_state = value_q;
  assign synced        = (state_q == ST_SYNCED);
  assign stale         = (state_q == ST_STALE);

  always_comb begin
    state_d      = state_q;
    value_d      = value_q;
    out_valid_d  = out_valid_q && !bus.out_ready;
    idle_d       = '0;
    err_thresh_d = err_thresh;
    err_sat_d    = err_sat;
    // Bit 8 of this 9-bit sum flags over/underflow; the delta sign says which.
    sum          = {1'b0, value_q} + {pop_evt.data[7], pop_evt.data};
    mag          = delta_mag(pop_evt.data);

    if (state_q == ST_SYNCED && !pop) begin
      idle_d = idle_q + 1'b1;
      if (idle_d == IDLE_W'(STALE_LIMIT)) state_d = ST_STALE;
    end

    if (pop) begin
      if (pop_evt.kind == KIND_KEY) begin
        state_d     = ST_SYNCED;
        value_d     = pop_evt.data;
        out_valid_d = 1'b1;
      end else if (state_q == ST_SYNCED && pop_evt.data != 8'd0) begin
        if (mag < DELTA_THRESHOLD) err_thresh_d = 1'b1;
        if (sum[8]) begin
          value_d   = pop_evt.data[7] ? 8'd0 : 8'd255;
          err_sat_d = 1'b1;
        end else begin
          value_d = sum[7:0];
        end
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_UNSYNC;
      value_q     <= 8'd0;
      out_valid_q <= 1'b0;
      idle_q      <= '0;
      err_thresh  <= 1'b0;
      err_sat     <= 1'b0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      out_valid_q <= out_valid_d;
      idle_q      <= idle_d;
      err_thresh  <= err_thresh_d;
      err_sat     <= err_sat_d;
    end
  end

endmodule
